mul_div_unit: RTL and testbench

//  Iterative 16-bit unsigned multiply/divide unit: the execute-side producer for the dual-write ops (ALUOp 3'b100 MUL, 3'b101 DIV).

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mul_div_unit.sv | 133 +++++++++++++
 tb/tb_mul_div_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU op codes, data width and multiply/divide FSM states
package cpu_pkg;

  localparam int DW = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative unsigned shift-add multiplier / restoring divider
// Result pair {ResHi, ResLo} is published with a one-cycle Done strobe after W iterations.
module mul_div_unit #(
  parameter int         W      = cpu_pkg::DW,
  parameter logic [2:0] OP_MUL = cpu_pkg::OP_MUL,
  parameter logic [2:0] OP_DIV = cpu_pkg::OP_DIV
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [2:0]   ALUOp,
  input  logic [W-1:0] OperandA,
  input  logic [W-1:0] OperandB,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] ResHi,
  output logic [W-1:0] ResLo,
  output logic         DivZero
);
  import cpu_pkg::*;

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic          is_div_q, is_div_d;
  logic [W-1:0]  res_hi_q, res_hi_d;
  logic [W-1:0]  res_lo_q, res_lo_d;
  logic          div_zero_q, div_zero_d;

  logic [W:0]    mul_sum;
  logic [W:0]    div_shifted;
  logic          div_fits;
  logic [W-1:0]  step_hi, step_lo;
  logic          accept;
  logic          start_div;

  // One iteration of either algorithm; opnd_q is the multiplicand or the divisor.
  always_comb begin
    mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    div_shifted = {hi_q, lo_q[W-1]};
    div_fits    = (div_shifted >= {1'b0, opnd_q});
    step_hi     = mul_sum[W:1];
    step_lo     = {mul_sum[0], lo_q[W-1:1]};
    if (is_div_q) begin
      step_hi = div_fits ? (div_shifted[W-1:0] - opnd_q) : div_shifted[W-1:0];
      step_lo = {lo_q[W-2:0], div_fits};
    end
  end

  assign start_div = (ALUOp == OP_DIV);
  assign accept    = Start && (ALUOp == OP_MUL || start_div) && (state_q != RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      RUN: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d  = DONE;
          res_hi_d = step_hi;
          res_lo_d = step_lo;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          is_div_d   = start_div;
          opnd_d     = start_div ? OperandB : OperandA;
          div_zero_d = 1'b0;
          // Divide by zero skips the iterations and publishes immediately.
          if (start_div && OperandB == '0) begin
            state_d    = DONE;
            res_hi_d   = OperandA;
            res_lo_d   = '1;
            div_zero_d = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CNT_LAST;
            hi_d    = '0;
            lo_d    = start_div ? OperandA : OperandB;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE);
  assign ResHi   = res_hi_q;
  assign ResLo   = res_lo_q;
  assign DivZero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed vector bench for mul_div_unit
module tb_mul_div_unit;
  import cpu_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  ALUOp;
  logic [15:0] OperandA;
  logic [15:0] OperandB;
  logic        Busy;
  logic        Done;
  logic [15:0] ResHi;
  logic [15:0] ResLo;
  logic        DivZero;

  int checks = 0;
  int errors = 0;

  mul_div_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .ALUOp    (ALUOp),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .Busy     (Busy),
    .Done     (Done),
    .ResHi    (ResHi),
    .ResLo    (ResLo),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    Start    = 1'b1;
    ALUOp    = op;
    OperandA = a;
    OperandB = b;
  endtask

  // Counts negedge samples after acceptance until Done; n = -1 on timeout.
  task automatic wait_done(output int n, output int busy_low);
    n        = -1;
    busy_low = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      Start    = 1'b0;
      OperandA = 16'hDEAD;
      OperandB = 16'hBEEF;
      if (Done) begin
        n = i;
        break;
      end
      if (!Busy) busy_low++;
    end
  endtask

  int n, busy_low, busy_cnt, done_cnt;
  logic [15:0] first_hi, first_lo;

  initial begin
    vecs[0] = '{OP_MUL, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 17};
    vecs[1] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
    vecs[2] = '{OP_DIV, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 17};
    vecs[3] = '{OP_DIV, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1};
    vecs[4] = '{OP_DIV, 16'h0009, 16'h0003, 16'h0000, 16'h0003, 1'b0, 17};
    vecs[5] = '{OP_MUL, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 17};
    vecs[6] = '{OP_DIV, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17};
    vecs[7] = '{OP_DIV, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 17};
    vecs[8] = '{OP_DIV, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 17};
    vecs[9] = '{OP_MUL, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 17};

    Reset    = 1'b1;
    Start    = 1'b0;
    ALUOp    = 3'b000;
    OperandA = '0;
    OperandB = '0;
    repeat (2) @(negedge Clk);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_reshi", 32'(ResHi), 32'd0);
    chk("reset_reslo", 32'(ResLo), 32'd0);
    chk("reset_divzero", 32'(DivZero), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int v = 0; v < 10; v++) begin
      start_op(vecs[v].op, vecs[v].a, vecs[v].b);
      wait_done(n, busy_low);
      chk($sformatf("v%0d_latency", v), 32'(n), 32'(vecs[v].lat));
      chk($sformatf("v%0d_busy_gaps", v), 32'(busy_low), 32'd0);
      chk($sformatf("v%0d_busy_at_done", v), 32'(Busy), 32'd0);
      chk($sformatf("v%0d_reshi", v), 32'(ResHi), 32'(vecs[v].hi));
      chk($sformatf("v%0d_reslo", v), 32'(ResLo), 32'(vecs[v].lo));
      chk($sformatf("v%0d_divzero", v), 32'(DivZero), 32'(vecs[v].dz));
      @(negedge Clk);
      chk($sformatf("v%0d_done_single", v), 32'(Done), 32'd0);
      chk($sformatf("v%0d_hold", v), {ResHi, ResLo}, {vecs[v].hi, vecs[v].lo});
    end

    // Non-MUL/DIV op is ignored
    start_op(3'b010, 16'h0011, 16'h0022);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
    end
    chk("other_op_busy", 32'(busy_cnt), 32'd0);
    chk("other_op_done", 32'(done_cnt), 32'd0);
    chk("other_op_hold", {ResHi, ResLo}, {16'h0001, 16'h0000});

    // Start mid-RUN must not disturb the in-flight multiply
    start_op(OP_MUL, 16'h0003, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    start_op(OP_DIV, 16'h0064, 16'h0007);
    done_cnt = 0;
    first_hi = 16'hFFFF;
    first_lo = 16'hFFFF;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done) begin
        if (done_cnt == 0) begin
          first_hi = ResHi;
          first_lo = ResLo;
        end
        done_cnt++;
      end
    end
    chk("midrun_done_count", 32'(done_cnt), 32'd1);
    chk("midrun_result", {first_hi, first_lo}, {16'h0000, 16'h000F});

    // Start during the DONE cycle is accepted back-to-back
    start_op(OP_MUL, 16'h0002, 16'h0003);
    wait_done(n, busy_low);
    chk("b2b_first_latency", 32'(n), 32'd17);
    chk("b2b_first_result", {ResHi, ResLo}, {16'h0000, 16'h0006});
    start_op(OP_DIV, 16'h0064, 16'h0007);
    wait_done(n, busy_low);
    chk("b2b_second_latency", 32'(n), 32'd17);
    chk("b2b_second_busy_gaps", 32'(busy_low), 32'd0);
    chk("b2b_second_result", {ResHi, ResLo}, {16'h0002, 16'h000E});

    // Asynchronous reset mid-RUN
    start_op(OP_MUL, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    chk("pre_reset_busy", 32'(Busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(Busy), 32'd0);
    chk("async_reset_done", 32'(Done), 32'd0);
    chk("async_reset_results", {ResHi, ResLo}, 32'd0);
    chk("async_reset_divzero", 32'(DivZero), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clk);
      if (Done) done_cnt++;
      if (Busy) busy_cnt++;
    end
    chk("post_reset_no_done", 32'(done_cnt), 32'd0);
    chk("post_reset_no_busy", 32'(busy_cnt), 32'd0);
    start_op(OP_MUL, 16'h0002, 16'h0002);
    wait_done(n, busy_low);
    chk("post_reset_mul_latency", 32'(n), 32'd17);
    chk("post_reset_mul_result", {ResHi, ResLo}, {16'h0000, 16'h0004});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
